fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 12'h000, byte address of the first fetch after reset.
REQ-002 SHALL have parameter: BUF_DEPTH, 2, number of entries in the output buffer; the only supported value is 2.
REQ-003 SHALL have port: clk  input  1  the only clock; all state updates on the rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: imem_addr  output  12  byte address presented to instruction memory; equals the PC register.
REQ-006 SHALL have port: imem_instr  input  16  instruction word returned combinationally for imem_addr in the same cycle.
REQ-007 SHALL have port: redirect_valid  input  1  branch/jump request, sampled each cycle.
REQ-008 SHALL have port: redirect_addr  input  12  redirect target byte address.
REQ-009 SHALL have port: halt_req  input  1  stops further fetching.
REQ-010 SHALL have port: out_valid  output  1  the buffer head holds a valid instruction.
REQ-011 SHALL have port: out_ready  input  1  the downstream decode stage accepts the head.
REQ-012 SHALL have port: out_instr  output  16  instruction at the buffer head.
REQ-013 SHALL have port: out_pc  output  12  byte address of out_instr.

Function
REQ-014 SHALL hold a 12-bit PC; bit 0 SHALL always be 0, and instructions are 16-bit at even byte addresses.
REQ-015 SHALL use a two-state FSM: RUN and HALTED.
REQ-016 SHALL fetch in RUN when no redirect occurs and there is buffer space (count<2, or count==2 with a pop this cycle): push {PC, imem_instr}, then PC<=PC+2.
REQ-017 SHALL wrap PC modulo 4096 (12'hFFE+2 -> 12'h000) with no flag.
REQ-018 SHALL give a fetch latency of 1 cycle: an instruction pushed in cycle N appears with out_valid=1 in cycle N+1 when the buffer was empty.
REQ-019 SHALL complete a handshake when out_valid&&out_ready; the head is popped at that edge.
REQ-020 SHALL allow push and pop in the same cycle; count is then unchanged.
REQ-021 SHALL hold out_instr and out_pc stable while out_valid=1 and out_ready=0.
REQ-022 SHALL have redirect_valid take priority over push: buffer flushed to count 0; PC<=redirect_addr with bit 0 cleared; no push that cycle; out_valid=0 next cycle.
REQ-023 SHALL treat a handshake coincident with a redirect as completed; the flush still discards the remaining entries.
REQ-024 SHALL, on halt_req=1 in RUN without redirect, transition to HALTED; no fetch occurs that cycle and none after; buffered entries drain normally.
REQ-025 SHALL, in HALTED, move to RUN only on redirect_valid (with REQ-022 applied); halt_req and redirect_valid together SHALL yield RUN with the redirect applied.
REQ-026 SHALL never overflow or underflow; a pop on an empty buffer is impossible because out_valid=0.

Reset
REQ-027 SHALL, on reset assertion and independent of clk: PC=RESET_PC (bit 0 cleared), FSM=RUN, count=0, out_valid=0, out_instr=16'h0000, out_pc=12'h000.
REQ-028 SHALL fetch from RESET_PC on the first rising edge after reset deasserts.
REQ-029 SHALL have reset asserted mid-operation discard all buffered entries with no partial handshake.

Structure
REQ-030 SHALL take from the shared package: the ADDR_W=12 and INSTR_W=16 constants, the PC_STEP=2 constant, and the fetch-state enum {RUN, HALTED}.
REQ-031 SHALL implement the 2-entry buffer as one sub-module, fetch_buf (synchronous push/pop/flush, count output, async reset).
REQ-032 SHALL keep the imem_addr path combinational from the PC register only, with no dependence on inputs.

Verification
REQ-033 SHALL cover: reset release with out_ready=1 and memory word(a)=a^16'hA5A5 -> out_pc sequence 000,002,004 starting cycle 2, with out_instr matching.
REQ-034 SHALL cover: out_ready=0 for 5 cycles -> buffer fills with 000/002, PC stops at 004, output stable; out_ready=1 -> 000,002,004 delivered in order.
REQ-035 SHALL cover: redirect_valid with redirect_addr=12'h3A1 while the buffer is full -> next cycle out_valid=0; then out_pc=12'h3A0 first.
REQ-036 SHALL cover: PC at 12'hFFE -> out_pc 12'hFFE followed by 12'h000.
REQ-037 SHALL cover: halt_req pulsed at PC=12'h010 -> no out_pc>=12'h010 delivered, buffer drains; redirect to 12'h100 -> fetch resumes at 12'h100.
REQ-038 SHALL cover: reset asserted mid-stream with count=2 -> out_valid=0 immediately and the first post-reset out_pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared widths, PC step, fetch state and buffer entry type
package fetch_unit_pkg;

    localparam int ADDR_W  = 12;
    localparam int INSTR_W = 16;

    localparam logic [ADDR_W-1:0] PC_STEP = 12'd2;
    // Instructions are halfword aligned, so PC bit 0 is forced low everywhere.
    localparam logic [ADDR_W-1:0] PC_MASK = ~12'd1;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - two-entry in-order buffer with push, pop and flush
// Entry 0 is always the head, so the head only changes on a pop, flush or push into empty.
module fetch_buf
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  fetch_entry_t i_push_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [1:0]   o_count,
    output logic         o_head_valid,
    output fetch_entry_t o_head_data
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    fetch_entry_t r_ent0;
    fetch_entry_t r_ent1;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    // Guards make overflow and underflow impossible even under bad requests.
    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != FULL) || w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 2'd0;
            r_ent0  <= '0;
            r_ent1  <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_ent0 <= i_push_data;
                    else                 r_ent1 <= i_push_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_ent0  <= r_ent1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_ent0 <= i_push_data;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_count      = r_count;
    assign o_head_valid = (r_count != 2'd0);
    assign o_head_data  = r_ent0;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, RUN/HALTED control and output buffer
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 12'h000,
    parameter int                BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic               halt_req,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    localparam logic [ADDR_W-1:0] PC_INIT = RESET_PC & PC_MASK;
    localparam logic [1:0]        FULL    = 2'(BUF_DEPTH);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [1:0]        w_count;
    logic              w_pop;
    logic              w_space;
    logic              w_fetch;
    logic              w_flush;
    fetch_entry_t      w_push_data;
    fetch_entry_t      w_head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (redirect_valid)                    w_state_next = RUN;
        else if (r_state == RUN && halt_req)   w_state_next = HALTED;
    end

    // A pop this cycle frees a slot, so a full buffer can still accept a fetch.
    assign w_pop   = out_valid && out_ready;
    assign w_space = (w_count != FULL) || w_pop;

    always_comb begin
        w_flush = redirect_valid;
        w_fetch = 1'b0;
        if (r_state == RUN && !redirect_valid && !halt_req && w_space) w_fetch = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               r_pc <= PC_INIT;
        else if (redirect_valid) r_pc <= redirect_addr & PC_MASK;
        else if (w_fetch)        r_pc <= r_pc + PC_STEP;
    end

    assign imem_addr         = r_pc;
    assign w_push_data.pc    = r_pc;
    assign w_push_data.instr = imem_instr;

    fetch_buf #(
        .DEPTH(BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_fetch),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_count     (w_count),
        .o_head_valid(out_valid),
        .o_head_data (w_head)
    );

    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table, corner sequences and random queue-model checks
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] imem_addr;
    logic [15:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [11:0] redirect_addr = 12'h000;
    logic        halt_req = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [11:0] out_pc;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [11:0] a);
        return {4'h0, a} ^ 16'hA5A5;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    fetch_unit #(
        .RESET_PC (12'h000),
        .BUF_DEPTH(2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .halt_req      (halt_req),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_head(input string name, input logic ev, input logic [11:0] epc,
                              input logic [11:0] eaddr);
        check({name, "_valid"}, 32'(out_valid), 32'(ev));
        check({name, "_addr"}, 32'(imem_addr), 32'(eaddr));
        if (ev) begin
            check({name, "_pc"}, 32'(out_pc), 32'(epc));
            check({name, "_instr"}, 32'(out_instr), 32'(mem_word(epc)));
        end
    endtask

    // Called on a falling edge; reset takes effect without any clock edge.
    task automatic do_reset(input string name);
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        out_ready      = 1'b0;
        reset          = 1'b1;
        #1;
        check({name, "_rst_valid"}, 32'(out_valid), 32'd0);
        check({name, "_rst_instr"}, 32'(out_instr), 32'h0000);
        check({name, "_rst_pc"}, 32'(out_pc), 32'h000);
        check({name, "_rst_addr"}, 32'(imem_addr), 32'h000);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit          rst;
        bit          redir;
        logic [11:0] raddr;
        bit          halt;
        bit          ready;
        bit          ev;
        logic [11:0] epc;
        logic [11:0] eaddr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rst, input bit redir, input logic [11:0] raddr, input bit halt,
                       input bit ready, input bit ev, input logic [11:0] epc,
                       input logic [11:0] eaddr);
        vec_t v;
        v.rst = rst; v.redir = redir; v.raddr = raddr; v.halt = halt;
        v.ready = ready; v.ev = ev; v.epc = epc; v.eaddr = eaddr;
        vecs.push_back(v);
    endtask

    logic [11:0] mq[$];
    logic [11:0] mpc;
    bit          mhalt;
    bit          mpop;

    initial begin
        @(negedge clk);
        do_reset("init");

        // Streaming from reset, then backpressure, redirect while full, and PC wrap.
        add(1, 0, 12'h000, 0, 1, 1, 12'h000, 12'h002);
        add(0, 0, 12'h000, 0, 1, 1, 12'h002, 12'h004);
        add(0, 0, 12'h000, 0, 1, 1, 12'h004, 12'h006);
        add(1, 0, 12'h000, 0, 0, 1, 12'h000, 12'h002);
        add(0, 0, 12'h000, 0, 0, 1, 12'h000, 12'h004);
        add(0, 0, 12'h000, 0, 0, 1, 12'h000, 12'h004);
        add(0, 0, 12'h000, 0, 0, 1, 12'h000, 12'h004);
        add(0, 0, 12'h000, 0, 0, 1, 12'h000, 12'h004);
        add(0, 0, 12'h000, 0, 1, 1, 12'h002, 12'h006);
        add(0, 0, 12'h000, 0, 1, 1, 12'h004, 12'h008);
        add(0, 0, 12'h000, 0, 0, 1, 12'h004, 12'h008);
        add(0, 1, 12'h3A1, 0, 0, 0, 12'h000, 12'h3A0);
        add(0, 0, 12'h000, 0, 0, 1, 12'h3A0, 12'h3A2);
        add(0, 0, 12'h000, 0, 1, 1, 12'h3A2, 12'h3A4);
        add(0, 1, 12'hFFF, 0, 1, 0, 12'h000, 12'hFFE);
        add(0, 0, 12'h000, 0, 1, 1, 12'hFFE, 12'h000);
        add(0, 0, 12'h000, 0, 1, 1, 12'h000, 12'h002);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset($sformatf("v%0d", i));
            redirect_valid = vecs[i].redir;
            redirect_addr  = vecs[i].raddr;
            halt_req       = vecs[i].halt;
            out_ready      = vecs[i].ready;
            step();
            check_head($sformatf("v%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].eaddr);
        end

        // Halt at PC 0x010: older entry drains, nothing newer appears, redirect resumes.
        do_reset("halt");
        out_ready = 1'b1;
        for (int i = 0; i < 20 && imem_addr != 12'h010; i++) step();
        check("halt_reach", 32'(imem_addr), 32'h010);
        check_head("halt_pre", 1'b1, 12'h00E, 12'h010);
        halt_req  = 1'b1;
        out_ready = 1'b0;
        step();
        check_head("halt_hold", 1'b1, 12'h00E, 12'h010);
        halt_req  = 1'b0;
        out_ready = 1'b1;
        step();
        check_head("halt_drain", 1'b0, 12'h000, 12'h010);
        for (int i = 0; i < 4; i++) begin
            step();
            check_head($sformatf("halt_idle%0d", i), 1'b0, 12'h000, 12'h010);
        end
        redirect_valid = 1'b1;
        redirect_addr  = 12'h100;
        out_ready      = 1'b0;
        step();
        redirect_valid = 1'b0;
        check_head("resume_redir", 1'b0, 12'h000, 12'h100);
        step();
        check_head("resume_first", 1'b1, 12'h100, 12'h102);
        step();
        check_head("resume_full", 1'b1, 12'h100, 12'h104);

        // Reset in the middle of a low phase with the buffer full.
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_pc", 32'(out_pc), 32'h000);
        check("mid_rst_instr", 32'(out_instr), 32'h0000);
        check("mid_rst_addr", 32'(imem_addr), 32'h000);
        @(negedge clk);
        reset     = 1'b0;
        out_ready = 1'b1;
        step();
        check_head("post_rst", 1'b1, 12'h000, 12'h002);

        // Random traffic against an in-order queue model of the fetch stream.
        do_reset("rand");
        mq.delete();
        mpc   = 12'h000;
        mhalt = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check_head("rand", mq.size() != 0, (mq.size() != 0) ? mq[0] : 12'h000, mpc);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_addr  = 12'($urandom);
            halt_req       = ($urandom_range(0, 15) == 0);
            out_ready      = ($urandom_range(0, 1) == 1);
            mpop = (mq.size() != 0) && out_ready;
            if (redirect_valid) begin
                mq.delete();
                mpc   = redirect_addr & 12'hFFE;
                mhalt = 1'b0;
            end else begin
                if (mpop) void'(mq.pop_front());
                if (!mhalt && halt_req) begin
                    mhalt = 1'b1;
                end else if (!mhalt && mq.size() < 2) begin
                    mq.push_back(mpc);
                    mpc = mpc + 12'd2;
                end
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
